uart_tx_drain: RTL and testbench

- Serial transmitter that drains the memory-mapped output byte buffer and shifts each byte onto a UART TX line, 8N1, LSB first.
- Sits directly downstream of the unified memory's output IO port:
  - consumes its head byte and occupancy count;
  - drives its pop strobe.
- Turns software writes to the output data register into characters on the board pin.

---
 rtl/uart_tx_drain_pkg.sv | 21 ++
 rtl/uart_tx_drain_if.sv | 17 +
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_tx_drain.sv | 109 ++++++++++
 tb/tb_uart_tx_drain.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_drain_pkg
// Brief    : Shared state encoding and constants for the UART TX drain block.
// Revision : 1.0
// ============================================================================
package uart_tx_drain_pkg;

    typedef enum logic [1:0] {
        UART_TX_IDLE  = 2'd0,
        UART_TX_START = 2'd1,
        UART_TX_DATA  = 2'd2,
        UART_TX_STOP  = 2'd3
    } uart_tx_state_e;

    // 50 MHz system clock at 115200 baud
    localparam int c_DEFAULT_CLKS_PER_BIT = 434;
    localparam int c_DATA_BITS            = 8;

endpackage
`default_nettype wire

// File: rtl/uart_tx_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_drain_if
// Brief    : Output byte buffer head/count/pop link between buffer and drain.
// Revision : 1.0
// ============================================================================
interface uart_tx_drain_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [COUNT_WIDTH-1:0] buf_count;
    logic [7:0]             buf_data;
    logic                   buf_pop;

    modport master (output buf_count, output buf_data, input buf_pop);
    modport slave  (input buf_count, input buf_data, output buf_pop);
endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Modulo-CLKS_PER_BIT counter with sync clear; ticks on last count.
// Revision : 1.0
// ============================================================================
module uart_baud_tick
    import uart_tx_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    output logic      o_tick
);
    localparam int              c_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_W-1:0]  c_LAST = c_W'(CLKS_PER_BIT - 1);

    logic [c_W-1:0] r_count;
    logic           w_tick;

    assign w_tick = (r_count == c_LAST);
    assign o_tick = w_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear || w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_drain
// Brief    : Drains the output byte buffer onto an 8N1 UART TX line, LSB first.
// Revision : 1.0
// ============================================================================
module uart_tx_drain
    import uart_tx_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    parameter int COUNT_WIDTH  = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         tx_enable,
    uart_tx_drain_if.slave    bus,
    output logic              tx,
    output logic              busy
);
    localparam logic [2:0] c_LAST_BIT = 3'(c_DATA_BITS - 1);

    uart_tx_state_e         r_state;
    logic [7:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic                   r_tx;
    logic                   r_busy;
    logic                   w_tick;
    logic                   w_has_data;
    logic                   w_pop;
    logic [COUNT_WIDTH-1:0] w_count;

    assign w_count    = bus.buf_count;
    assign w_has_data = |w_count;

    // Pop only where a new frame can start: idle, or the final stop-bit cycle
    assign w_pop = !reset && tx_enable && w_has_data &&
                   ((r_state == UART_TX_IDLE) || ((r_state == UART_TX_STOP) && w_tick));

    assign bus.buf_pop = w_pop;
    assign tx          = r_tx;
    assign busy        = r_busy;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_state == UART_TX_IDLE),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= UART_TX_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                UART_TX_IDLE: begin
                    if (w_pop) begin
                        r_state <= UART_TX_START;
                        r_shift <= bus.buf_data;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                UART_TX_START: begin
                    if (w_tick) begin
                        r_state   <= UART_TX_DATA;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                UART_TX_DATA: begin
                    if (w_tick) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state <= UART_TX_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                UART_TX_STOP: begin
                    if (w_tick) begin
                        if (w_pop) begin
                            r_state <= UART_TX_START;
                            r_shift <= bus.buf_data;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= UART_TX_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= UART_TX_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_drain
// Brief    : Self-checking bench for uart_tx_drain against a frame-timeline model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_drain;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic reset;
    logic tx_enable;
    logic tx;
    logic busy;

    uart_tx_drain_if #(.COUNT_WIDTH(32)) bus ();

    uart_tx_drain #(
        .CLKS_PER_BIT (CPB),
        .COUNT_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_enable (tx_enable),
        .bus       (bus),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the buffer as a queue, plus position within the current frame
    logic [7:0] q[$];
    logic       m_busy = 1'b0;
    int         m_k    = 0;
    logic [7:0] m_byte = 8'h00;
    int         dut_pops    = 0;
    int         busy_cycles = 0;
    logic       rec_on = 1'b0;
    logic       rec_tx[$];
    logic       random_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        int b;
        if (!m_busy) return 1'b1;
        b = m_k / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    task automatic drive_buf();
        if (q.size() == 0) begin
            bus.buf_count = '0;
            bus.buf_data  = 8'($urandom);
        end else begin
            bus.buf_count = q.size();
            if (random_mode) bus.buf_count = bus.buf_count | ($urandom & 32'hFF00_0000);
            bus.buf_data  = q[0];
        end
    endtask

    task automatic tick();
        logic exp_pop;
        @(negedge clk);
        exp_pop = !reset && tx_enable && (q.size() != 0) && (!m_busy || m_k == FRAME - 1);
        check("tx", tx, model_tx());
        check("busy", busy, m_busy);
        check("pop", bus.buf_pop, exp_pop);
        if (bus.buf_pop === 1'b1) dut_pops++;
        if (busy === 1'b1) busy_cycles++;
        if (rec_on) rec_tx.push_back(tx);
        @(posedge clk);
        if (reset) begin
            m_busy = 1'b0;
        end else if (exp_pop) begin
            m_byte = q.pop_front();
            m_busy = 1'b1;
            m_k    = 0;
        end else if (m_busy) begin
            if (m_k == FRAME - 1) m_busy = 1'b0;
            else m_k++;
        end
        #1;
        drive_buf();
    endtask

    initial begin
        int         p0;
        int         b0;
        logic [7:0] dec[$];
        int         starts[$];
        int         i;
        logic [7:0] b;

        reset     = 1'b1;
        tx_enable = 1'b0;
        drive_buf();
        repeat (3) tick();
        reset = 1'b0;

        // 1: idle after reset with an empty buffer
        tx_enable = 1'b1;
        p0 = dut_pops;
        repeat (100) tick();
        check("t1_pops", dut_pops - p0, 0);

        // 2: single byte 0x55
        q.push_back(8'h55);
        drive_buf();
        p0 = dut_pops; b0 = busy_cycles;
        repeat (45) tick();
        check("t2_pops", dut_pops - p0, 1);
        check("t2_busy_cycles", busy_cycles - b0, FRAME);

        // 3: back-to-back A5, 3C decoded from the recorded line
        rec_tx.delete();
        rec_on = 1'b1;
        q.push_back(8'hA5);
        q.push_back(8'h3C);
        drive_buf();
        p0 = dut_pops; b0 = busy_cycles;
        repeat (90) tick();
        rec_on = 1'b0;
        i = 0;
        while (i + FRAME <= rec_tx.size()) begin
            if (rec_tx[i] == 1'b0) begin
                for (int j = 0; j < 8; j++) b[j] = rec_tx[i + CPB*(1+j) + CPB/2];
                check("t3_stop_bit", rec_tx[i + 9*CPB + CPB/2], 1);
                dec.push_back(b);
                starts.push_back(i);
                i += FRAME;
            end else begin
                i++;
            end
        end
        check("t3_frames", dec.size(), 2);
        if (dec.size() == 2) begin
            check("t3_byte0", dec[0], 8'hA5);
            check("t3_byte1", dec[1], 8'h3C);
            check("t3_gap", starts[1] - starts[0], FRAME);
        end
        check("t3_pops", dut_pops - p0, 2);
        check("t3_busy_cycles", busy_cycles - b0, 2 * FRAME);

        // 4: disable mid-frame, then re-enable
        q.push_back(8'h11);
        q.push_back(8'h22);
        drive_buf();
        p0 = dut_pops;
        repeat (10) tick();
        tx_enable = 1'b0;
        repeat (40) tick();
        check("t4_pops_disabled", dut_pops - p0, 1);
        check("t4_idle_tx", tx, 1);
        check("t4_idle_busy", busy, 0);
        tx_enable = 1'b1;
        repeat (45) tick();
        check("t4_pops_reenabled", dut_pops - p0, 2);

        // 5: async reset between edges during DATA
        q.push_back(8'hC3);
        drive_buf();
        for (int n = 0; n < 60 && !(m_busy && m_k == 17); n++) tick();
        check("t5_reached_bit", (m_busy && m_k == 17), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_tx", tx, 1);
        check("t5_async_busy", busy, 0);
        check("t5_async_pop", bus.buf_pop, 0);
        m_busy = 1'b0;
        q.push_back(8'h77);
        drive_buf();
        p0 = dut_pops;
        repeat (5) tick();
        check("t5_pops_in_reset", dut_pops - p0, 0);
        q.delete();
        drive_buf();
        reset = 1'b0;
        repeat (20) tick();
        check("t5_pops_after", dut_pops - p0, 0);

        // 6: empty-buffer guard then first nonzero count
        p0 = dut_pops;
        repeat (50) tick();
        check("t6_pops_empty", dut_pops - p0, 0);
        q.push_back(8'h5A);
        drive_buf();
        tick();
        check("t6_first_pop", dut_pops - p0, 1);
        repeat (45) tick();

        // Randomized traffic with enable toggling and wide nonzero counts
        random_mode = 1'b1;
        repeat (3000) begin
            if ($urandom_range(24, 0) == 0) q.push_back(8'($urandom));
            if ($urandom_range(59, 0) == 0) tx_enable = ~tx_enable;
            drive_buf();
            tick();
        end
        tx_enable = 1'b1;
        repeat (q.size() * FRAME + 2 * FRAME) tick();
        check("rand_drained", q.size(), 0);
        check("rand_idle_tx", tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
